// File: rtl/rv_enc_pkg.sv
// Shared RV32I encoding constants: instruction formats, major opcodes and
// the legal signed range of each immediate format.
package rv_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    // Branch and jump offsets are byte offsets in units of 2, hence the even maxima.
    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMMB_MIN  = -4096;
    localparam int IMMB_MAX  = 4094;
    localparam int IMMJ_MIN  = -(1 << 20);
    localparam int IMMJ_MAX  = (1 << 20) - 2;

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response bundle of the immediate encoder: valid/ready request side,
// valid/ready encoded-word side and the running error count.
interface imm_encoder_if #(parameter int CNT_W = 16);
    import rv_enc_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_fmt;
    logic [6:0]       in_opcode;
    logic [4:0]       in_rd;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [2:0]       in_funct3;
    logic [6:0]       in_funct7;
    logic [31:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_err;
    logic [CNT_W-1:0] err_count;

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err, err_count
    );

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err, err_count
    );

endinterface

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding encoded words; head is presented combinationally.
// Pushes while full and pops while empty are ignored.
module instr_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == OCC_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/imm_encoder.sv
// Packs register/funct fields and a signed immediate into an RV32I word,
// substituting a NOP and flagging an error when the immediate cannot be encoded.
module imm_encoder
    import rv_enc_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    imm_encoder_if.slave bus
);
    logic               [31:0] enc_word;
    logic                      enc_err;
    logic                      legal;
    logic signed        [31:0] imm_s;
    logic               [31:0] imm;
    logic                      push;
    logic                      pop;
    logic                      full;
    logic                      empty;
    logic               [32:0] head;
    logic          [CNT_W-1:0] err_cnt;

    assign imm   = bus.in_imm;
    assign imm_s = $signed(bus.in_imm);

    // Scatter the immediate per format; any illegal combination collapses to a NOP.
    always_comb begin
        enc_word = RV_NOP;
        legal    = 1'b0;
        case (bus.in_fmt)
            FMT_R: begin
                legal    = 1'b1;
                enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                            bus.in_rd, bus.in_opcode};
            end
            FMT_I: begin
                legal    = (imm_s >= IMM12_MIN) && (imm_s <= IMM12_MAX);
                enc_word = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            end
            FMT_S: begin
                legal    = (imm_s >= IMM12_MIN) && (imm_s <= IMM12_MAX);
                enc_word = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                            imm[4:0], bus.in_opcode};
            end
            FMT_B: begin
                legal    = (imm_s >= IMMB_MIN) && (imm_s <= IMMB_MAX) && !imm[0];
                enc_word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                            imm[4:1], imm[11], bus.in_opcode};
            end
            FMT_U: begin
                legal    = (imm[11:0] == 12'h000);
                enc_word = {imm[31:12], bus.in_rd, bus.in_opcode};
            end
            FMT_J: begin
                legal    = (imm_s >= IMMJ_MIN) && (imm_s <= IMMJ_MAX) && !imm[0];
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
            end
            default: begin
                legal    = 1'b0;
                enc_word = RV_NOP;
            end
        endcase
        if (!legal) enc_word = RV_NOP;
        enc_err = ~legal;
    end

    assign push         = bus.in_valid & bus.in_ready;
    assign pop          = bus.out_valid & bus.out_ready;
    assign bus.in_ready = ~full;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (33)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({enc_err, enc_word}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // FIFO storage is not reset, so the head is masked while empty.
    assign bus.out_valid = ~empty;
    assign bus.out_instr = empty ? 32'h0 : head[31:0];
    assign bus.out_err   = empty ? 1'b0  : head[32];
    assign bus.err_count = err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (push && enc_err && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed encodings, error handling,
// backpressure, asynchronous reset and a randomized run against a reference model.
module tb_imm_encoder;
    import rv_enc_pkg::*;

    localparam int DEPTH = 2;
    localparam int CW    = 3;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } req_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_err  = 0;
    logic [32:0] q[$];

    always #5 clk = ~clk;

    imm_encoder_if #(.CNT_W(CW)) bus ();

    imm_encoder #(
        .DEPTH (DEPTH),
        .CNT_W (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic req_t mk(input logic [2:0] fmt, input logic [6:0] opc, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] imm);
        req_t r;
        r.fmt = fmt; r.opc = opc; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
        r.f3 = f3; r.f7 = f7; r.imm = imm;
        return r;
    endfunction

    // Reference encoder: fields placed by shift/mask arithmetic, legality by integer range.
    function automatic logic [32:0] refEncode(input req_t r);
        longint v;
        longint w;
        bit     ok;
        v  = longint'($signed(r.imm));
        ok = 1'b1;
        w  = longint'(r.opc);
        case (r.fmt)
            3'd0: w += (longint'(r.f7) << 25) + (longint'(r.rs2) << 20) + (longint'(r.rs1) << 15)
                     + (longint'(r.f3) << 12) + (longint'(r.rd) << 7);
            3'd1: begin
                ok = (v >= -2048) && (v <= 2047);
                w += ((v & 'hFFF) << 20) + (longint'(r.rs1) << 15) + (longint'(r.f3) << 12)
                     + (longint'(r.rd) << 7);
            end
            3'd2: begin
                ok = (v >= -2048) && (v <= 2047);
                w += (((v >> 5) & 'h7F) << 25) + (longint'(r.rs2) << 20) + (longint'(r.rs1) << 15)
                     + (longint'(r.f3) << 12) + ((v & 'h1F) << 7);
            end
            3'd3: begin
                ok = (v >= -4096) && (v <= 4094) && ((v & 1) == 0);
                w += (((v >> 12) & 1) << 31) + (((v >> 5) & 'h3F) << 25) + (longint'(r.rs2) << 20)
                     + (longint'(r.rs1) << 15) + (longint'(r.f3) << 12) + (((v >> 1) & 'hF) << 8)
                     + (((v >> 11) & 1) << 7);
            end
            3'd4: begin
                ok = ((v & 'hFFF) == 0);
                w += (v & 'hFFFF_F000) + (longint'(r.rd) << 7);
            end
            3'd5: begin
                ok = (v >= -(64'sd1 << 20)) && (v <= (64'sd1 << 20) - 2) && ((v & 1) == 0);
                w += (((v >> 20) & 1) << 31) + (((v >> 1) & 'h3FF) << 21) + (((v >> 11) & 1) << 20)
                     + (((v >> 12) & 'hFF) << 12) + (longint'(r.rd) << 7);
            end
            default: ok = 1'b0;
        endcase
        if (!ok) return {1'b1, 32'h0000_0013};
        return {1'b0, w[31:0]};
    endfunction

    function automatic void bumpErr();
        if (exp_err < (1 << CW) - 1) exp_err++;
    endfunction

    task automatic driveReq(input req_t r);
        bus.in_fmt    = r.fmt;
        bus.in_opcode = r.opc;
        bus.in_rd     = r.rd;
        bus.in_rs1    = r.rs1;
        bus.in_rs2    = r.rs2;
        bus.in_funct3 = r.f3;
        bus.in_funct7 = r.f7;
        bus.in_imm    = r.imm;
    endtask

    // One request into an empty FIFO with the consumer ready; word must appear one cycle after accept.
    task automatic applyStimulus(input string tag, input req_t r, input logic [31:0] exp_word,
                                 input logic exp_e);
        @(negedge clk);
        driveReq(r);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        checkOutput({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (exp_e) bumpErr();
        checkOutput({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
        checkOutput({tag, "_instr"}, 64'(bus.out_instr), 64'(exp_word));
        checkOutput({tag, "_err"}, 64'(bus.out_err), 64'(exp_e));
        checkOutput({tag, "_err_count"}, 64'(bus.err_count), 64'(exp_err));
    endtask

    function automatic logic [31:0] randImm();
        logic [31:0] edges [13];
        edges = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4096, -32'sd4096,
                  -32'sd4098, 32'd1048574, 32'd1048576, -32'sd1048576, 32'h1234_5000, 32'd0};
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'(int'($urandom_range(0, 10000)) - 5000);
            2:       return 32'(int'($urandom_range(0, 1 << 22)) - (1 << 21));
            default: return edges[$urandom_range(0, 12)];
        endcase
    endfunction

    initial begin
        req_t r;
        req_t ra;
        req_t rb;
        req_t rc;
        bit   fire_in;
        bit   fire_out;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        driveReq(mk(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0));

        // Reset state while held low across clock edges.
        #12;
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("rst_out_instr", 64'(bus.out_instr), 64'(0));
        checkOutput("rst_out_err", 64'(bus.out_err), 64'(0));
        checkOutput("rst_err_count", 64'(bus.err_count), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'(1));

        // Directed encodings.
        applyStimulus("addi", mk(3'd1, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF),
                      32'hFFF0_0093, 1'b0);
        applyStimulus("sw", mk(3'd2, OPC_STORE, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'd8),
                      32'h0021_A423, 1'b0);
        applyStimulus("beq", mk(3'd3, OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4),
                      32'hFE00_0EE3, 1'b0);
        applyStimulus("jal", mk(3'd5, OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048),
                      32'h0010_00EF, 1'b0);
        applyStimulus("lui", mk(3'd4, OPC_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000),
                      32'h1234_52B7, 1'b0);
        applyStimulus("err_i2048", mk(3'd1, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048),
                      32'h0000_0013, 1'b1);
        applyStimulus("err_b3", mk(3'd3, OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3),
                      32'h0000_0013, 1'b1);
        applyStimulus("err_u1", mk(3'd4, OPC_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1),
                      32'h0000_0013, 1'b1);
        checkOutput("err_count_three", 64'(bus.err_count), 64'(3));
        @(negedge clk);
        @(negedge clk);
        checkOutput("drain_valid", 64'(bus.out_valid), 64'(0));

        // Backpressure: three offered, two fit, head holds until released.
        ra = mk(3'd1, OPC_OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd1);
        rb = mk(3'd1, OPC_OP_IMM, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 32'd2);
        rc = mk(3'd1, OPC_OP_IMM, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'd3);
        bus.out_ready = 1'b0;
        driveReq(ra);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_head_a0", 64'(bus.out_instr), 64'(refEncode(ra)));
        @(negedge clk);
        driveReq(rb);
        @(negedge clk);
        driveReq(rc);
        checkOutput("bp_full", 64'(bus.in_ready), 64'(0));
        checkOutput("bp_head_a1", 64'(bus.out_instr), 64'(refEncode(ra)));
        @(negedge clk);
        checkOutput("bp_head_a2", 64'(bus.out_instr), 64'(refEncode(ra)));
        checkOutput("bp_valid", 64'(bus.out_valid), 64'(1));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_head_b", 64'(bus.out_instr), 64'(refEncode(rb)));
        @(negedge clk);
        checkOutput("bp_in_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;
        checkOutput("bp_head_c", 64'(bus.out_instr), 64'(refEncode(rc)));
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("bp_empty", 64'(bus.out_valid), 64'(0));

        // Asynchronous reset with two entries queued, one of them erroneous.
        @(negedge clk);
        bus.out_ready = 1'b0;
        r = mk(3'd1, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5000);
        driveReq(r);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bumpErr();
        driveReq(ra);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput("mr_err_before", 64'(bus.err_count), 64'(exp_err));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mr_out_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("mr_err_count", 64'(bus.err_count), 64'(0));
        checkOutput("mr_out_instr", 64'(bus.out_instr), 64'(0));
        @(negedge clk);
        rst_n   = 1'b1;
        exp_err = 0;
        applyStimulus("mr_sw", mk(3'd2, OPC_STORE, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'd8),
                      32'h0021_A423, 1'b0);
        @(negedge clk);
        @(negedge clk);

        // Randomized stream with random backpressure against the reference queue.
        q.delete();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            checkOutput("rnd_valid", 64'(bus.out_valid), 64'(q.size() != 0));
            if (q.size() != 0) begin
                checkOutput("rnd_instr", 64'(bus.out_instr), 64'(q[0][31:0]));
                checkOutput("rnd_err", 64'(bus.out_err), 64'(q[0][32]));
            end
            checkOutput("rnd_in_ready", 64'(bus.in_ready), 64'(q.size() < DEPTH));
            checkOutput("rnd_err_count", 64'(bus.err_count), 64'(exp_err));
            r = mk(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                   5'($urandom), 3'($urandom), 7'($urandom), randImm());
            driveReq(r);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            fire_in  = bus.in_valid && (q.size() < DEPTH);
            fire_out = bus.out_ready && (q.size() != 0);
            @(posedge clk);
            if (fire_out) void'(q.pop_front());
            if (fire_in) begin
                q.push_back(refEncode(r));
                if (refEncode(r) >> 32) bumpErr();
            end
        end

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
